// File: rtl/gpio_in_debounce.sv
// Per-channel input conditioning: 2-FF synchronizer, counter-based debouncer
// and registered rise/fall pulses with a combined any_edge flag.
module gpio_in_debounce #(
  parameter int unsigned CH        = 8,
  parameter int unsigned DB_CYCLES = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [CH-1:0] pin_in,
  output logic [CH-1:0] gpio_in,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic          any_edge
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CH-1:0]    sync1;
  logic [CH-1:0]    sync2;
  logic [CNT_W-1:0] cnt     [CH];
  logic [CNT_W-1:0] cnt_nxt [CH];
  logic [CH-1:0]    gpio_nxt;
  logic [CH-1:0]    rise_nxt;
  logic [CH-1:0]    fall_nxt;

  // A level is accepted on the cycle the count has already reached its
  // maximum and sync2 still disagrees, so the count never wraps.
  always_comb begin
    gpio_nxt = gpio_in;
    rise_nxt = '0;
    fall_nxt = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      cnt_nxt[i] = '0;
      if (en && (sync2[i] != gpio_in[i])) begin
        if (cnt[i] == CNT_MAX) begin
          gpio_nxt[i] = sync2[i];
          rise_nxt[i] = sync2[i];
          fall_nxt[i] = ~sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      gpio_in  <= '0;
      rise     <= '0;
      fall     <= '0;
      any_edge <= 1'b0;
      for (int unsigned i = 0; i < CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1    <= pin_in;
      sync2    <= sync1;
      gpio_in  <= gpio_nxt;
      rise     <= rise_nxt;
      fall     <= fall_nxt;
      any_edge <= |(rise_nxt | fall_nxt);
      for (int unsigned i = 0; i < CH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed bench for gpio_in_debounce with CH=4, DB_CYCLES=4: per-cycle
// vector table plus hand sequences for glitch restart, enable gating and reset.
module tb_gpio_in_debounce;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] pin_in;
  logic [3:0] gpio_in;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       any_edge;

  int checks   = 0;
  int failures = 0;

  gpio_in_debounce #(
    .CH(4),
    .DB_CYCLES(4),
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .pin_in(pin_in),
    .gpio_in(gpio_in),
    .rise(rise),
    .fall(fall),
    .any_edge(any_edge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] pin;
    logic [3:0] g;
    logic [3:0] r;
    logic [3:0] f;
    logic       a;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic e, input logic [3:0] pin,
                     input logic [3:0] g, input logic [3:0] r,
                     input logic [3:0] f, input logic a);
    vec_t v;
    v.rst = rst; v.en = e; v.pin = pin; v.g = g; v.r = r; v.f = f; v.a = a;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] g, input logic [3:0] r,
                     input logic [3:0] f, input logic a);
    checks++;
    if ({gpio_in, rise, fall, any_edge} !== {g, r, f, a}) begin
      failures++;
      $display("FAIL %s: got gpio_in=%h rise=%h fall=%h any_edge=%b, want gpio_in=%h rise=%h fall=%h any_edge=%b",
               name, gpio_in, rise, fall, any_edge, g, r, f, a);
    end
  endtask

  initial begin
    reset  = 1'b1;
    en     = 1'b1;
    pin_in = 4'h0;

    // reset held with all pins high, then full-latency acceptance
    for (int i = 0; i < 3; i++) add(1, 1, 4'hF, 4'h0, 4'h0, 4'h0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 4'hF, 4'h0, 4'h0, 4'h0, 0);
    add(0, 1, 4'hF, 4'hF, 4'hF, 4'h0, 1);
    add(0, 1, 4'hF, 4'hF, 4'h0, 4'h0, 0);
    // re-reset with pins low, then channel 0 step
    for (int i = 0; i < 2; i++) add(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    add(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 4'h1, 4'h0, 4'h0, 4'h0, 0);
    add(0, 1, 4'h1, 4'h1, 4'h1, 4'h0, 1);
    add(0, 1, 4'h1, 4'h1, 4'h0, 4'h0, 0);
    // channel 1: 3-cycle pulse rejected
    for (int i = 0; i < 3; i++) add(0, 1, 4'h3, 4'h1, 4'h0, 4'h0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 4'h1, 4'h1, 4'h0, 4'h0, 0);
    // channel 1: 4-cycle pulse accepted, then its falling edge accepted
    for (int i = 0; i < 4; i++) add(0, 1, 4'h3, 4'h1, 4'h0, 4'h0, 0);
    add(0, 1, 4'h1, 4'h1, 4'h0, 4'h0, 0);
    add(0, 1, 4'h1, 4'h3, 4'h2, 4'h0, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 4'h1, 4'h3, 4'h0, 4'h0, 0);
    add(0, 1, 4'h1, 4'h1, 4'h0, 4'h2, 1);
    add(0, 1, 4'h1, 4'h1, 4'h0, 4'h0, 0);

    foreach (tbl[i]) begin
      reset  = tbl[i].rst;
      en     = tbl[i].en;
      pin_in = tbl[i].pin;
      step();
      chk($sformatf("vec%0d", i), tbl[i].g, tbl[i].r, tbl[i].f, tbl[i].a);
    end

    // channel 2: 1-0-1 toggle mid-count restarts the count
    pin_in = 4'h5;
    step(); chk("t4_sync1", 4'h1, 4'h0, 4'h0, 0);
    step(); chk("t4_sync2", 4'h1, 4'h0, 4'h0, 0);
    step(); chk("t4_cnt1", 4'h1, 4'h0, 4'h0, 0);
    pin_in = 4'h1;
    step(); chk("t4_dip", 4'h1, 4'h0, 4'h0, 0);
    pin_in = 4'h5;
    step(); chk("t4_final_edge", 4'h1, 4'h0, 4'h0, 0);
    for (int i = 1; i <= 4; i++) begin
      step(); chk($sformatf("t4_wait%0d", i), 4'h1, 4'h0, 4'h0, 0);
    end
    step(); chk("t4_accept", 4'h5, 4'h4, 4'h0, 1);
    step(); chk("t4_after", 4'h5, 4'h0, 4'h0, 0);

    // channel 3 changes while disabled: frozen, then 4 edges after enable
    en     = 1'b0;
    pin_in = 4'hD;
    for (int i = 0; i < 6; i++) begin
      step(); chk($sformatf("t5_frozen%0d", i), 4'h5, 4'h0, 4'h0, 0);
    end
    en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(); chk($sformatf("t5_en_wait%0d", i), 4'h5, 4'h0, 4'h0, 0);
    end
    step(); chk("t5_accept", 4'hD, 4'h8, 4'h0, 1);
    step(); chk("t5_after", 4'hD, 4'h0, 4'h0, 0);

    // channel 0 falls, reset lands at cnt=2; full latency after release
    pin_in = 4'hC;
    step(); chk("t6_sync1", 4'hD, 4'h0, 4'h0, 0);
    step(); chk("t6_sync2", 4'hD, 4'h0, 4'h0, 0);
    step(); chk("t6_cnt1", 4'hD, 4'h0, 4'h0, 0);
    step(); chk("t6_cnt2", 4'hD, 4'h0, 4'h0, 0);
    reset = 1'b1;
    step(); chk("t6_reset", 4'h0, 4'h0, 4'h0, 0);
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step(); chk($sformatf("t6_wait%0d", i), 4'h0, 4'h0, 4'h0, 0);
    end
    step(); chk("t6_accept", 4'hC, 4'hC, 4'h0, 1);
    step(); chk("t6_after", 4'hC, 4'h0, 4'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
